alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Buffered issue/retire stage wrapped around the combinational alu_32.
- Accepts ALU commands (a, b, op, tag) over a valid/ready handshake into a DEPTH-entry FIFO.
- The FIFO head drives alu_32 directly. Each result and its flags are captured into an output register, which retires over a second valid/ready handshake.
- Also keeps a saturating overflow-event counter for software/debug visibility.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the opaque tag carried alongside each command.
- OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset.
- flush  input  1  synchronous clear of the FIFO and the output register.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_a  input  32  operand a.
- in_b  input  32  operand b.
- in_op  input  4  alu_32 opcode; legal values are 4'b0000..4'b1000.
- in_tag  input  TAG_W  opaque ID, returned with the result.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer takes the result.
- out_result  output  32  alu_32 result.
- out_carry  output  1  alu_32 carryout.
- out_overflow  output  1  alu_32 overflow.
- out_zero  output  1  alu_32 zero.
- out_illegal  output  1  opcode was above 4'b1000.
- out_tag  output  TAG_W  tag of this result.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_count  output  OVF_CNT_W  number of overflow results captured, saturating.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values while rst_n is low:
  - FIFO empty, fifo_count=0, in_ready=1 (in_ready is held 1 because the FIFO is empty).
  - out_valid=0, out_result=0, all flags 0, out_tag=0, ovf_count=0.
- Push:
  - Occurs when in_valid && in_ready at a clock edge.
  - in_ready is registered: in_ready = (fifo_count != DEPTH) and does not depend on a same-cycle pop.
  - While full, in_ready=0 even if a pop happens that cycle.
- Pop/capture:
  - Condition: FIFO non-empty && (!out_valid || out_ready).
  - On a capture edge, the output register loads alu_32 outputs computed from the FIFO head, plus the head tag and illegal bit. out_valid is then 1.
- Retire without refill: if out_valid && out_ready and no pop occurs, out_valid goes to 0. Data fields keep their last value.
- Latency: a command pushed at edge k into an empty FIFO with a free output register is captured at edge k+1. out_valid is high in the cycle following edge k+1. There is no combinational path from in_* to out_*.
- Throughput: one result per cycle when in_valid and out_ready are held high.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. A pop while empty is impossible; the pop condition includes non-empty.
- Pointers: read and write pointers wrap modulo DEPTH. Commands retire in strict FIFO order.
- Illegal opcode (in_op > 4'b1000):
  - Still queued and captured in order.
  - out_illegal=1, out_result=0, out_carry=out_overflow=out_zero=0.
  - Does not increment ovf_count.
- ovf_count: incremented on each capture edge where the captured out_overflow=1. Holds at all-ones once saturated. Cleared only by rst_n, not by flush.
- flush:
  - Highest priority among synchronous events.
  - Empties the FIFO, forces fifo_count=0 and out_valid=0.
  - A same-cycle push or capture is discarded.
  - in_ready=1 the next cycle.
- Reset mid-operation: asserting rst_n low asynchronously clears all state, including in-flight FIFO entries and the held result. No result is emitted after reset deasserts until a new push.
- Hold under backpressure: while out_valid && !out_ready, the out_* fields are stable.

Test Plan:
- Reset: hold rst_n=0, then release -> out_valid=0, in_ready=1, fifo_count=0, ovf_count=0, all out_* fields 0.
- Add overflow: push a=32'h7FFFFFF1, b=1312342, op=4'b0000, tag=3 with out_ready=1 -> out_valid one cycle after the push edge; out_result=32'h80140647, out_overflow=1, out_tag=3, ovf_count=1.
- Sub overflow: push a=1334212, b=32'h80000011, op=4'b0001 -> out_result=32'h80145BB3, out_overflow=1, out_zero=0, ovf_count increments.
- Backpressure (DEPTH=4): hold out_ready=0 and push tags 0..5 -> tag 0 in the output register, tags 1..4 in the FIFO, fifo_count=4, in_ready=0, tag 5 stalled. Then set out_ready=1 -> tags 0..5 retire in order, one per cycle, with no loss or duplication.
- Illegal op: push op=4'b1010 -> out_illegal=1, out_result=0, all flags 0, ovf_count unchanged.
- Flush and reset mid-stream:
  - With 3 entries queued and out_valid=1, pulse flush together with in_valid -> next cycle fifo_count=0, out_valid=0, in_ready=1, pushed command dropped, ovf_count retained.
  - Repeat with an rst_n low pulse instead of flush -> everything cleared, including ovf_count.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: a buffered issue/retire stage built around the combinational alu_32.
//
// Commands (a, b, op, tag) arrive over a valid/ready handshake and are queued
// in a DEPTH-entry FIFO. The FIFO head feeds alu_32 directly. The result, its
// flags, the tag and an illegal-opcode bit are captured into an output
// register, which retires over a second valid/ready handshake. A saturating
// counter tracks how many captured results had the overflow flag set.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   flush                 synchronous clear of the FIFO and the output register
//   in_valid / in_ready   command handshake (in_ready is registered)
//   in_a, in_b, in_op     operands and alu_32 opcode (legal 0..8)
//   in_tag                opaque ID that is returned with the result
//   out_valid / out_ready result handshake
//   out_result, out_carry, out_overflow, out_zero   alu_32 outputs
//   out_illegal           the opcode was above 4'b1000
//   out_tag               tag of the held result
//   fifo_count            current FIFO occupancy
//   ovf_count             saturating count of captured overflow results
//
// alu_32 opcodes:
//   0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 signed set-less-than,
//   7 shift left logical (b[4:0]), 8 shift right logical (b[4:0]).
//   For sub, carry is the carry out of a + ~b + 1, i.e. 1 means no borrow.

module alu_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        zero
);

  logic [32:0] sum_ext;
  logic [32:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    result   = 32'd0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      4'd0: begin
        result   = sum_ext[31:0];
        carry    = sum_ext[32];
        overflow = (a[31] == b[31]) && (sum_ext[31] != a[31]);
      end
      4'd1: begin
        result   = diff_ext[31:0];
        carry    = diff_ext[32];
        overflow = (a[31] != b[31]) && (diff_ext[31] != a[31]);
      end
      4'd2: result = a & b;
      4'd3: result = a | b;
      4'd4: result = a ^ b;
      4'd5: result = ~(a | b);
      4'd6: result = {31'd0, ($signed(a) < $signed(b))};
      4'd7: result = a << b[4:0];
      4'd8: result = a >> b[4:0];
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

module alu_issue_stage #(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4,
  parameter int OVF_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [3:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_carry,
  output logic                     out_overflow,
  output logic                     out_zero,
  output logic                     out_illegal,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [OVF_CNT_W-1:0]     ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // Command storage, no reset needed: occupancy is tracked by the pointers.
  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [3:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             in_ready_q;

  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic             out_carry_q;
  logic             out_overflow_q;
  logic             out_zero_q;
  logic             out_illegal_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [OVF_CNT_W-1:0] ovf_count_q;

  logic push;
  logic pop;
  logic retire_only;

  logic [31:0] head_a;
  logic [31:0] head_b;
  logic [3:0]  head_op;
  logic        head_illegal;

  logic [31:0] alu_result;
  logic        alu_carry;
  logic        alu_overflow;
  logic        alu_zero;

  // Captured values after forcing illegal opcodes to an all-zero result.
  logic [31:0] cap_result;
  logic        cap_carry;
  logic        cap_overflow;
  logic        cap_zero;

  assign push        = in_valid && in_ready_q;
  assign pop         = (count != '0) && (!out_valid_q || out_ready);
  assign retire_only = out_valid_q && out_ready && !pop;

  assign head_a       = mem_a[rd_ptr];
  assign head_b       = mem_b[rd_ptr];
  assign head_op      = mem_op[rd_ptr];
  assign head_illegal = (head_op > 4'd8);

  alu_32 u_alu (
    .a        (head_a),
    .b        (head_b),
    .op       (head_op),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // alu_32 reports zero=1 for its default case, so illegal ops must mask every flag.
  assign cap_result   = head_illegal ? 32'd0 : alu_result;
  assign cap_carry    = head_illegal ? 1'b0  : alu_carry;
  assign cap_overflow = head_illegal ? 1'b0  : alu_overflow;
  assign cap_zero     = head_illegal ? 1'b0  : alu_zero;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_op[wr_ptr]  <= in_op;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      // Registered ready: reflects next occupancy, so a same-cycle pop
      // while full cannot open the input until the following cycle.
      in_ready_q <= (count_next != FULL_COUNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_result_q   <= 32'd0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q    <= 1'b1;
      out_result_q   <= cap_result;
      out_carry_q    <= cap_carry;
      out_overflow_q <= cap_overflow;
      out_zero_q     <= cap_zero;
      out_illegal_q  <= head_illegal;
      out_tag_q      <= mem_tag[rd_ptr];
    end else if (retire_only) begin
      out_valid_q <= 1'b0;
    end
  end

  // Overflow counter survives flush; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else if (!flush && pop && cap_overflow && (ovf_count_q != '1)) begin
      ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_illegal  = out_illegal_q;
  assign out_tag      = out_tag_q;
  assign fifo_count   = count;
  assign ovf_count    = ovf_count_q;

endmodule
